// File: rtl/minicpu_multicycle.sv
// Multi-cycle LoongArch-subset core: one instruction walks IF/ID/EX/MEM/WB,
// with variable-latency req/ack handshakes on the instruction and data ports.
module minicpu_multicycle #(
    parameter logic [31:0] RESET_PC  = 32'h1c00_0000,
    parameter int          NUM_GPR   = 32,
    parameter bit          EN_EXT_BR = 1'b1
) (
    input  logic        clk,
    input  logic        resetn,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_ack,
    input  logic [31:0] inst_rdata,
    output logic        data_req,
    output logic        data_we,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    input  logic        data_ack,
    input  logic [31:0] data_rdata,
    output logic        illegal_inst,
    output logic [31:0] debug_wb_pc,
    output logic        debug_wb_rf_we,
    output logic [4:0]  debug_wb_rf_wnum,
    output logic [31:0] debug_wb_rf_wdata
);

    // state | meaning
    // S_IF  | fetch: inst_req held with inst_addr=pc until inst_ack
    // S_ID  | decode, read operands; illegal word skips to next pc
    // S_EX  | ALU / address / branch resolution
    // S_MEM | data_req held with addr/we/wdata until data_ack
    // S_WB  | register write, pc update, debug_wb_* valid
    typedef enum logic [2:0] {S_IF, S_ID, S_EX, S_MEM, S_WB} state_t;

    state_t      state, state_nxt;
    logic        run;
    logic [31:0] pc, ir, op_a, op_b, alu_out, npc, mdr;
    logic [31:0] gpr [32];

    logic [4:0]  rd, rj, rk, src2;
    logic        is_add, is_sub, is_addi, is_ld, is_st, is_beq, is_bne, is_b;
    logic        legal, gr_we, gpr_wr, taken;
    logic [31:0] simm12, br_offs, rj_val, src2_val, alu_res, wb_value;

    assign rd   = ir[4:0];
    assign rj   = ir[9:5];
    assign rk   = ir[14:10];

    assign is_add  = (ir[31:15] == 17'h00020);
    assign is_sub  = (ir[31:15] == 17'h00022);
    assign is_addi = (ir[31:22] == 10'h00a);
    assign is_ld   = (ir[31:22] == 10'h0a2);
    assign is_st   = (ir[31:22] == 10'h0a6);
    assign is_bne  = (ir[31:26] == 6'h17);
    assign is_beq  = EN_EXT_BR && (ir[31:26] == 6'h16);
    assign is_b    = EN_EXT_BR && (ir[31:26] == 6'h14);
    assign legal   = is_add | is_sub | is_addi | is_ld | is_st | is_beq | is_bne | is_b;
    assign gr_we   = is_add | is_sub | is_addi | is_ld;
    assign gpr_wr  = gr_we && (rd != 5'd0) && (32'(rd) < NUM_GPR);

    // Branches and stores compare/store rd, so rd takes the second read port.
    assign src2     = (is_st | is_bne | is_beq) ? rd : rk;
    assign rj_val   = (rj != 5'd0 && 32'(rj) < NUM_GPR) ? gpr[rj] : 32'd0;
    assign src2_val = (src2 != 5'd0 && 32'(src2) < NUM_GPR) ? gpr[src2] : 32'd0;

    assign simm12  = {{20{ir[21]}}, ir[21:10]};
    assign br_offs = is_b ? {{4{ir[9]}}, ir[9:0], ir[25:10], 2'b00}
                          : {{14{ir[25]}}, ir[25:10], 2'b00};
    assign taken   = is_b | (is_bne & (op_a != op_b)) | (is_beq & (op_a == op_b));

    always_comb begin
        alu_res = op_a + simm12;
        if (is_add)      alu_res = op_a + op_b;
        else if (is_sub) alu_res = op_a - op_b;
    end

    assign wb_value = is_ld ? mdr : alu_out;

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IF:    if (run && inst_ack) state_nxt = S_ID;
            S_ID:    state_nxt = legal ? S_EX : S_IF;
            S_EX:    state_nxt = (is_ld | is_st) ? S_MEM : S_WB;
            S_MEM:   if (data_ack) state_nxt = S_WB;
            S_WB:    state_nxt = S_IF;
            default: state_nxt = S_IF;
        endcase
    end

    // run keeps inst_req low until the first edge after reset release.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= S_IF;
            run     <= 1'b0;
            pc      <= RESET_PC;
            ir      <= '0;
            op_a    <= '0;
            op_b    <= '0;
            alu_out <= '0;
            npc     <= '0;
            mdr     <= '0;
        end else begin
            state <= state_nxt;
            run   <= 1'b1;
            unique case (state)
                S_IF:  if (run && inst_ack) ir <= inst_rdata;
                S_ID: begin
                    op_a <= rj_val;
                    op_b <= src2_val;
                    if (!legal) pc <= pc + 32'd4;
                end
                S_EX: begin
                    alu_out <= alu_res;
                    npc     <= taken ? pc + br_offs : pc + 32'd4;
                end
                S_MEM: if (data_ack && is_ld) mdr <= data_rdata;
                S_WB:  pc <= npc;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < 32; i++) gpr[i] <= '0;
        end else if (state == S_WB && gpr_wr) begin
            gpr[rd] <= wb_value;
        end
    end

    assign inst_req          = run && (state == S_IF);
    assign inst_addr         = pc;
    assign data_req          = (state == S_MEM);
    assign data_we           = data_req && is_st;
    assign data_addr         = data_req ? alu_out : 32'd0;
    assign data_wdata        = (data_req && is_st) ? op_b : 32'd0;
    assign illegal_inst      = (state == S_ID) && !legal;
    assign debug_wb_pc       = (state == S_WB) ? pc : 32'd0;
    assign debug_wb_rf_we    = (state == S_WB) && gr_we && (rd != 5'd0);
    assign debug_wb_rf_wnum  = debug_wb_rf_we ? rd : 5'd0;
    assign debug_wb_rf_wdata = debug_wb_rf_we ? wb_value : 32'd0;

endmodule

// File: tb/tb_minicpu_multicycle.sv
// Bench for minicpu_multicycle: acts as both SRAMs with random wait states and
// checks every cycle against an instruction-level model of the architecture.
module tb_minicpu_multicycle;

    localparam logic [31:0] RESET_PC = 32'h1c00_0000;
    localparam logic [16:0] OP_ADD  = 17'h00020;
    localparam logic [16:0] OP_SUB  = 17'h00022;
    localparam logic [9:0]  OP_ADDI = 10'h00a;
    localparam logic [9:0]  OP_LD   = 10'h0a2;
    localparam logic [9:0]  OP_ST   = 10'h0a6;
    localparam logic [5:0]  OP_BEQ  = 6'h16;
    localparam logic [5:0]  OP_BNE  = 6'h17;
    localparam int K_ADD = 0, K_SUB = 1, K_ADDI = 2, K_LD = 3, K_ST = 4,
                   K_BEQ = 5, K_BNE = 6, K_B = 7, K_ILL = 8;

    logic        clk = 1'b0, resetn = 1'b0;
    logic        inst_req, inst_ack, data_req, data_we, data_ack, illegal_inst;
    logic [31:0] inst_addr, inst_rdata, data_addr, data_wdata, data_rdata;
    logic [31:0] debug_wb_pc, debug_wb_rf_wdata;
    logic        debug_wb_rf_we;
    logic [4:0]  debug_wb_rf_wnum;

    always #5 clk = ~clk;

    minicpu_multicycle dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_ack(inst_ack), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_we(data_we), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_ack(data_ack), .data_rdata(data_rdata), .illegal_inst(illegal_inst),
        .debug_wb_pc(debug_wb_pc), .debug_wb_rf_we(debug_wb_rf_we),
        .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
    );

    int          total = 0, bad = 0;
    logic [31:0] m_gpr [32];
    logic [31:0] m_pc;
    logic [31:0] dmem [logic [31:0]];
    logic [31:0] last_wdata, last_wpc, pcb;
    logic [4:0]  last_wnum;
    logic        last_we;
    int          dreq_cycles = 0, ill_seen = 0;

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", n, got, exp, $time);
        end
    endtask

    task automatic chk1(input string n, input logic got, input logic exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%b exp=%b t=%0t", n, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] rv(input logic [4:0] i);
        return (i == 5'd0) ? 32'd0 : m_gpr[i];
    endfunction

    function automatic logic [31:0] mread(input logic [31:0] a);
        return dmem.exists(a) ? dmem[a] : (a ^ 32'h5a5a_c3c3);
    endfunction

    function automatic int kind_of(input logic [31:0] w);
        if (w[31:15] == OP_ADD)  return K_ADD;
        if (w[31:15] == OP_SUB)  return K_SUB;
        if (w[31:22] == OP_ADDI) return K_ADDI;
        if (w[31:22] == OP_LD)   return K_LD;
        if (w[31:22] == OP_ST)   return K_ST;
        if (w[31:26] == OP_BEQ)  return K_BEQ;
        if (w[31:26] == OP_BNE)  return K_BNE;
        if (w[31:26] == 6'h14)   return K_B;
        return K_ILL;
    endfunction

    function automatic logic [31:0] e3r(input logic [16:0] op, input logic [4:0] rk, input logic [4:0] rj, input logic [4:0] rd);
        return {op, rk, rj, rd};
    endfunction
    function automatic logic [31:0] e2ri(input logic [9:0] op, input logic [11:0] imm, input logic [4:0] rj, input logic [4:0] rd);
        return {op, imm, rj, rd};
    endfunction
    function automatic logic [31:0] ebr(input logic [5:0] op, input logic [15:0] o, input logic [4:0] rj, input logic [4:0] rd);
        return {op, o, rj, rd};
    endfunction
    function automatic logic [31:0] eb(input logic [25:0] o);
        return {6'h14, o[15:0], o[25:16]};
    endfunction

    task automatic noise();
        inst_ack   = 1'($urandom_range(0, 1));
        inst_rdata = $urandom();
        data_ack   = 1'($urandom_range(0, 1));
        data_rdata = $urandom();
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_gpr[i] = 32'd0;
        m_pc = RESET_PC;
    endtask

    // Executes one instruction end to end; the DUT is checked at every negedge.
    task automatic run_inst(input logic [31:0] iw, input int iwait, input int dwait, input bit abort);
        int          w, kind;
        logic [4:0]  rd, rj, rk;
        logic [31:0] a, simm, offs, addr, res, nxt;
        logic        we, taken;
        w = (iwait < 0) ? int'($urandom_range(0, 3)) : iwait;
        for (int k = 0; k <= w; k++) begin
            @(negedge clk);
            chk1("fetch_req", inst_req, 1'b1);
            chk("fetch_addr", inst_addr, m_pc);
            chk1("fetch_dreq", data_req, 1'b0);
            chk1("fetch_wbwe", debug_wb_rf_we, 1'b0);
            chk1("fetch_ill", illegal_inst, 1'b0);
            inst_ack   = (k == w);
            inst_rdata = (k == w) ? iw : $urandom();
            data_ack   = 1'($urandom_range(0, 1));
            data_rdata = $urandom();
        end
        kind = kind_of(iw);
        rd = iw[4:0]; rj = iw[9:5]; rk = iw[14:10];
        if (kind == K_ILL) begin
            @(negedge clk);
            chk1("ill_pulse", illegal_inst, 1'b1);
            if (illegal_inst === 1'b1) ill_seen++;
            chk1("ill_ireq", inst_req, 1'b0);
            chk1("ill_dreq", data_req, 1'b0);
            chk1("ill_wbwe", debug_wb_rf_we, 1'b0);
            noise();
            m_pc = m_pc + 32'd4;
            return;
        end
        repeat (2) begin
            @(negedge clk);
            chk1("idex_ill", illegal_inst, 1'b0);
            chk1("idex_ireq", inst_req, 1'b0);
            chk1("idex_dreq", data_req, 1'b0);
            chk1("idex_wbwe", debug_wb_rf_we, 1'b0);
            noise();
        end
        a     = rv(rj);
        simm  = {{20{iw[21]}}, iw[21:10]};
        offs  = (kind == K_B) ? {{4{iw[9]}}, iw[9:0], iw[25:10], 2'b00}
                              : {{14{iw[25]}}, iw[25:10], 2'b00};
        addr  = a + simm;
        res   = 32'd0;
        taken = 1'b0;
        case (kind)
            K_ADD:  res = a + rv(rk);
            K_SUB:  res = a - rv(rk);
            K_ADDI: res = a + simm;
            K_BEQ:  taken = (a == rv(rd));
            K_BNE:  taken = (a != rv(rd));
            K_B:    taken = 1'b1;
            default: ;
        endcase
        if (kind == K_LD || kind == K_ST) begin
            w = (dwait < 0) ? int'($urandom_range(0, 4)) : dwait;
            for (int k = 0; k <= w; k++) begin
                @(negedge clk);
                chk1("mem_req", data_req, 1'b1);
                chk1("mem_we", data_we, kind == K_ST);
                chk("mem_addr", data_addr, addr);
                if (kind == K_ST) chk("mem_wdata", data_wdata, rv(rd));
                chk1("mem_ireq", inst_req, 1'b0);
                chk1("mem_wbwe", debug_wb_rf_we, 1'b0);
                if (data_req === 1'b1) dreq_cycles++;
                if (abort && k == 1) begin
                    data_ack = 1'b0;
                    #2 resetn = 1'b0;
                    #1;
                    chk1("rst_dreq_async", data_req, 1'b0);
                    chk1("rst_ireq", inst_req, 1'b0);
                    chk("rst_iaddr", inst_addr, RESET_PC);
                    chk1("rst_dwe", data_we, 1'b0);
                    chk("rst_daddr", data_addr, 32'd0);
                    chk1("rst_wbwe", debug_wb_rf_we, 1'b0);
                    chk("rst_wbpc", debug_wb_pc, 32'd0);
                    data_ack = 1'b1;
                    inst_ack = 1'b1;
                    model_reset();
                    return;
                end
                inst_ack   = 1'($urandom_range(0, 1));
                inst_rdata = $urandom();
                data_ack   = (k == w);
                data_rdata = (kind == K_LD && k == w) ? mread(addr) : $urandom();
            end
            if (kind == K_LD) res = mread(addr);
            else dmem[addr] = rv(rd);
        end
        we  = (kind == K_ADD || kind == K_SUB || kind == K_ADDI || kind == K_LD) && (rd != 5'd0);
        nxt = taken ? m_pc + offs : m_pc + 32'd4;
        @(negedge clk);
        chk("wb_pc", debug_wb_pc, m_pc);
        chk1("wb_we", debug_wb_rf_we, we);
        if (we) begin
            chk("wb_wnum", 32'(debug_wb_rf_wnum), 32'(rd));
            chk("wb_wdata", debug_wb_rf_wdata, res);
        end
        chk1("wb_ireq", inst_req, 1'b0);
        chk1("wb_dreq", data_req, 1'b0);
        last_we = debug_wb_rf_we; last_wnum = debug_wb_rf_wnum;
        last_wdata = debug_wb_rf_wdata; last_wpc = debug_wb_pc;
        noise();
        if (we) m_gpr[rd] = res;
        m_pc = nxt;
    endtask

    task automatic release_reset();
        @(negedge clk);
        resetn = 1'b1;
        inst_ack = 1'b1; inst_rdata = 32'hffff_ffff; data_ack = 1'b1;
        #1 chk1("req_before_edge", inst_req, 1'b0);
        @(posedge clk);
        #1;
        chk1("req_after_edge", inst_req, 1'b1);
        chk("addr_after_rst", inst_addr, RESET_PC);
        inst_ack = 1'b0; data_ack = 1'b0;
    endtask

    function automatic logic [31:0] gen_rand();
        int         sel;
        logic [4:0] rd, rj, rk;
        sel = $urandom_range(0, 19);
        rd = 5'($urandom_range(0, 7));
        rj = 5'($urandom_range(0, 7));
        rk = 5'($urandom_range(0, 7));
        if (sel <= 3)  return e3r(OP_ADD, rk, rj, rd);
        if (sel <= 6)  return e3r(OP_SUB, rk, rj, rd);
        if (sel <= 10) return e2ri(OP_ADDI, 12'($urandom()), rj, rd);
        if (sel <= 12) return e2ri(OP_LD, 12'($urandom_range(0, 63) * 4), rj, rd);
        if (sel <= 14) return e2ri(OP_ST, 12'($urandom_range(0, 63) * 4), rj, rd);
        if (sel == 15) return ebr(OP_BEQ, 16'($urandom()), rj, rd);
        if (sel == 16) return ebr(OP_BNE, 16'($urandom()), rj, rd);
        if (sel == 17) return eb(26'($urandom()));
        if (sel == 18) return 32'hffff_ffff;
        return 32'h0000_0000;
    endfunction

    initial begin
        inst_ack = 1'b0; inst_rdata = 32'd0; data_ack = 1'b0; data_rdata = 32'd0;
        model_reset();
        #12;
        chk1("rst0_ireq", inst_req, 1'b0);
        chk("rst0_iaddr", inst_addr, RESET_PC);
        chk1("rst0_dreq", data_req, 1'b0);
        chk("rst0_wbpc", debug_wb_pc, 32'd0);
        chk1("rst0_wbwe", debug_wb_rf_we, 1'b0);
        chk1("rst0_ill", illegal_inst, 1'b0);
        release_reset();

        run_inst(e2ri(OP_ADDI, 12'd5, 5'd0, 5'd1), 0, 0, 0);
        chk("t1_wdata", last_wdata, 32'd5);
        chk("t1_pc", last_wpc, 32'h1c00_0000);
        chk("t1_wnum", 32'(last_wnum), 32'd1);

        run_inst(e2ri(OP_ADDI, 12'd7, 5'd0, 5'd1), -1, 0, 0);
        run_inst(e2ri(OP_ADDI, 12'hffe, 5'd0, 5'd2), -1, 0, 0);
        run_inst(e3r(OP_ADD, 5'd2, 5'd1, 5'd3), -1, 0, 0);
        chk("add_7_m2", last_wdata, 32'd5);
        run_inst(e3r(OP_SUB, 5'd2, 5'd1, 5'd4), -1, 0, 0);
        chk("sub_7_m2", last_wdata, 32'd9);

        run_inst(e2ri(OP_ADDI, 12'h2a9, 5'd0, 5'd1), -1, 0, 0);
        repeat (6) run_inst(e3r(OP_ADD, 5'd1, 5'd1, 5'd1), -1, 0, 0);
        run_inst(e2ri(OP_ADDI, 12'h015, 5'd1, 5'd1), -1, 0, 0);
        chk("build_aa55", last_wdata, 32'h0000_aa55);

        dreq_cycles = 0;
        pcb = m_pc;
        run_inst(e2ri(OP_ST, 12'h010, 5'd0, 5'd1), 0, 3, 0);
        chk("st_dreq_cycles", 32'(dreq_cycles), 32'd4);
        chk1("st_no_we", last_we, 1'b0);
        chk("st_wb_pc", last_wpc, pcb);
        run_inst(e2ri(OP_LD, 12'h010, 5'd0, 5'd5), 0, 3, 0);
        chk("ld_aa55", last_wdata, 32'h0000_aa55);
        chk("ld_wnum", 32'(last_wnum), 32'd5);

        pcb = m_pc; run_inst(ebr(OP_BNE, 16'hffff, 5'd1, 5'd2), -1, 0, 0);
        chk("bne_taken", m_pc, pcb - 32'd4);
        pcb = m_pc; run_inst(ebr(OP_BNE, 16'hffff, 5'd1, 5'd1), -1, 0, 0);
        chk("bne_fall", m_pc, pcb + 32'd4);
        pcb = m_pc; run_inst(ebr(OP_BEQ, 16'hffff, 5'd1, 5'd1), -1, 0, 0);
        chk("beq_taken", m_pc, pcb - 32'd4);
        pcb = m_pc; run_inst(ebr(OP_BEQ, 16'hffff, 5'd1, 5'd2), -1, 0, 0);
        chk("beq_fall", m_pc, pcb + 32'd4);
        pcb = m_pc; run_inst(eb(26'd3), -1, 0, 0);
        chk("b_plus3", m_pc, pcb + 32'd12);

        run_inst(e2ri(OP_ADDI, 12'd1, 5'd0, 5'd0), -1, 0, 0);
        chk1("r0_no_we", last_we, 1'b0);
        run_inst(e2ri(OP_ADDI, 12'd3, 5'd0, 5'd7), -1, 0, 0);
        chk("r0_reads_0", last_wdata, 32'd3);

        ill_seen = 0;
        pcb = m_pc;
        run_inst(32'hffff_ffff, -1, 0, 0);
        run_inst(e2ri(OP_ADDI, 12'd1, 5'd0, 5'd6), -1, 0, 0);
        chk("ill_pulses", 32'(ill_seen), 32'd1);
        chk("ill_skip_pc", last_wpc, pcb + 32'd4);

        for (int i = 0; i < 400; i++) run_inst(gen_rand(), -1, -1, 0);

        run_inst(e2ri(OP_ST, 12'h020, 5'd0, 5'd1), 0, 8, 1);
        repeat (2) @(negedge clk);
        chk1("rst_hold_ireq", inst_req, 1'b0);
        release_reset();
        for (int i = 1; i < 32; i++)
            run_inst(e3r(OP_ADD, 5'd0, 5'(i), 5'(i)), -1, 0, 0);
        for (int i = 0; i < 150; i++) run_inst(gen_rand(), -1, -1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
